// File: rtl/seq_mul_responder_pkg.sv
// Shared constants for the sequential multiply path of the ALU.
// Opcode and RL/RH pseudo-register addresses sit beside the legacy opcode defines.
package seq_mul_responder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam logic [7:0] SMUL_SEQ = 8'h2A;
  localparam logic [3:0] RL_ADDR  = 4'hE;
  localparam logic [3:0] RH_ADDR  = 4'hF;

endpackage

// File: rtl/seq_mul_responder_step.sv
// One shift-add iteration: adds the multiplicand shifted by the bit position
// into the accumulator when the current multiplier bit is set.
module mul_shift_add_step #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic               bit_i,
  input  logic [CW-1:0]      count_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] addend;

  always_comb begin
    addend = {{WIDTH{1'b0}}, mcand_i} << count_i;
    acc_o  = bit_i ? (acc_i + addend) : acc_i;
  end

endmodule

// File: rtl/seq_mul_responder.sv
// Iterative shift-add multiplier responding to ALU multiply requests; one
// multiplier bit per clock, sign applied to the magnitude product at the end.
module seq_mul_responder
  import seq_mul_responder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oRL,
  output logic [WIDTH-1:0] oRH
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   rl_q, rl_d;
  logic [WIDTH-1:0]   rh_q, rh_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   a_mag, b_mag;

  mul_shift_add_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[count_q]),
    .count_i (count_q),
    .acc_o   (step_acc)
  );

  // Magnitudes stay W-bit unsigned so that -2^(W-1) maps to 2^(W-1) exactly.
  always_comb begin
    a_mag   = (iSigned && iA[WIDTH-1]) ? -iA : iA;
    b_mag   = (iSigned && iB[WIDTH-1]) ? -iB : iB;
    product = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rl_d     = rl_q;
    rh_d     = rh_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (iStart) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        if (count_q == CW'(WIDTH - 1)) begin
          count_d = '0;
          state_d = S_FIX;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_FIX: begin
        rl_d    = product[WIDTH-1:0];
        rh_d    = product[2*WIDTH-1:WIDTH];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rl_q     <= '0;
      rh_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rl_q     <= rl_d;
      rh_q     <= rh_d;
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oRL   = rl_q;
  assign oRH   = rh_q;

endmodule

// File: tb/tb_seq_mul_responder.sv
// Self-checking bench for seq_mul_responder: directed table, random requests
// against an arithmetic product model, and multi-cycle corner sequences.
module tb_seq_mul_responder;

  localparam int W   = 16;
  localparam int LAT = W + 1;  // edges from accept edge to the edge raising oDone

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         iStart = 1'b0;
  logic         iSigned = 1'b0;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic         oBusy, oDone;
  logic [W-1:0] oRL, oRH;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_responder #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oRL     (oRL),
    .oRH     (oRH)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit           sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({16'b0, a}) * longint'({16'b0, b});
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    iStart = 1'b1; iSigned = s; iA = a; iB = b;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iSigned = 1'($urandom); iA = W'($urandom); iB = W'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int k = 1; k <= 60 && !ok; k++) begin
      @(posedge Clock); #1;
      lat = k;
      if (oDone) ok = 1'b1;
    end
  endtask

  task automatic run_and_check(input string tag, input bit s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [31:0] exp);
    int lat; bit ok;
    start_req(s, a, b);
    chk({tag, "_busy_hi"}, 64'(oBusy), 64'd1);
    wait_done(lat, ok);
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy_lo"}, 64'(oBusy), 64'd0);
    chk({tag, "_product"}, 64'({oRH, oRL}), 64'(exp));
    @(posedge Clock); #1;
    chk({tag, "_done_pulse"}, 64'(oDone), 64'd0);
  endtask

  initial begin
    int lat, ndone, first_lat, second_lat;
    logic [31:0] r1, r2;

    vecs[0] = '{0, 16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{1, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB};
    vecs[3] = '{1, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[4] = '{0, 16'h0000, 16'h1234, 32'h0000_0000};
    vecs[5] = '{1, 16'h8000, 16'h0001, 32'hFFFF_8000};
    vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    vecs[7] = '{0, 16'h8000, 16'h8000, 32'h4000_0000};
    vecs[8] = '{1, 16'h7FFF, 16'h8000, 32'hC000_8000};

    repeat (3) @(posedge Clock);
    #1;
    chk("reset_busy", 64'(oBusy), 64'd0);
    chk("reset_done", 64'(oDone), 64'd0);
    chk("reset_rl", 64'(oRL), 64'd0);
    chk("reset_rh", 64'(oRH), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 30; i++) begin
      bit s; logic [W-1:0] a, b;
      s = 1'($urandom); a = W'($urandom); b = W'($urandom);
      if (i % 7 == 0) a = W'(16'h8000);
      run_and_check($sformatf("rnd%0d", i), s, a, b, model(s, a, b));
    end

    // iStart pulses at clocks 3 and 9 of a busy request must be ignored
    start_req(0, 16'd3, 16'd5);
    ndone = 0; first_lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      iStart = (k == 3 || k == 9);
      iA = 16'd7; iB = 16'd9; iSigned = 1'b1;
      @(posedge Clock); #1;
      if (oDone) begin
        ndone++;
        if (ndone == 1) begin first_lat = k; r1 = {oRH, oRL}; end
      end
    end
    iStart = 1'b0;
    chk("ignore_ndone", 64'(ndone), 64'd1);
    chk("ignore_latency", 64'(first_lat), 64'(LAT));
    chk("ignore_product", 64'(r1), 64'h0F);
    chk("ignore_idle", 64'(oBusy), 64'd0);

    // iStart held high: second request taken in DONE, next oDone W+2 later
    start_req(1, 16'hFFFD, 16'h0007);
    ndone = 0; first_lat = 0; second_lat = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge Clock);
      iStart = (k <= 35);
      iSigned = (k < 18);
      iA = (k < 18) ? 16'hFFFD : 16'd100;
      iB = (k < 18) ? 16'h0007 : 16'd200;
      @(posedge Clock); #1;
      if (oDone) begin
        ndone++;
        if (ndone == 1) begin first_lat = k; r1 = {oRH, oRL}; end
        if (ndone == 2) begin second_lat = k; r2 = {oRH, oRL}; end
      end
    end
    iStart = 1'b0;
    chk("b2b_ndone", 64'(ndone), 64'd2);
    chk("b2b_first_lat", 64'(first_lat), 64'(LAT));
    chk("b2b_gap", 64'(second_lat - first_lat), 64'(W + 2));
    chk("b2b_first_prod", 64'(r1), 64'hFFFF_FFEB);
    chk("b2b_second_prod", 64'(r2), 64'd20000);
    chk("b2b_idle_after", 64'(oBusy), 64'd0);

    // asynchronous reset in the middle of RUN discards the request
    start_req(0, 16'h1234, 16'h5678);
    repeat (7) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(oBusy), 64'd0);
    chk("rst_mid_done", 64'(oDone), 64'd0);
    chk("rst_mid_rl", 64'(oRL), 64'd0);
    chk("rst_mid_rh", 64'(oRH), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge Clock); #1;
      if (oDone || oBusy) ndone++;
    end
    chk("rst_mid_quiet", 64'(ndone), 64'd0);
    run_and_check("after_rst", 0, 16'h1234, 16'h5678, 32'h0626_0060);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
